// File: rtl/temp_spi_reader_if.sv
// rtl/temp_spi_reader_if.sv - sensor-side serial bus plus temperature result bus
interface temp_spi_reader_if;
  logic       enable;
  logic       miso;
  logic       sclk;
  logic       cs_n;
  logic [5:0] temp;
  logic       temp_valid;
  logic       busy;

  modport master (
    input  enable,
    input  miso,
    output sclk,
    output cs_n,
    output temp,
    output temp_valid,
    output busy
  );

  modport slave (
    output enable,
    output miso,
    input  sclk,
    input  cs_n,
    input  temp,
    input  temp_valid,
    input  busy
  );
endinterface

// File: rtl/temp_spi_reader.sv
// rtl/temp_spi_reader.sv - periodic SPI mode-0 temperature read, saturated to 6 bits
module temp_spi_reader #(
  parameter int CLK_DIV       = 25,
  parameter int DATA_BITS     = 8,
  parameter int SAMPLE_PERIOD = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  temp_spi_reader_if.master     bus
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam int TMR_W = $clog2(SAMPLE_PERIOD + 1);

  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]     BITS_ALL = BIT_W'(DATA_BITS);
  localparam logic [TMR_W-1:0]     TMR_LAST = TMR_W'(SAMPLE_PERIOD - 1);
  localparam logic [DATA_BITS-1:0] SAT_MAX  = DATA_BITS'(63);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

  state_t               state;
  logic [DIV_W-1:0]     div_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [TMR_W-1:0]     timer;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 first_conv;
  logic                 sclk_q;
  logic                 cs_n_q;
  logic                 temp_valid_q;
  logic [5:0]           temp_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      timer        <= '0;
      shift_reg    <= '0;
      first_conv   <= 1'b1;
      sclk_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      temp_valid_q <= 1'b0;
      temp_q       <= '0;
    end else begin
      temp_valid_q <= 1'b0;
      // A low enable re-arms the immediate start, so the first conversion after it rises is not delayed
      if (!bus.enable) first_conv <= 1'b1;
      if (timer < TMR_LAST) timer <= timer + 1'b1;

      case (state)
        IDLE: begin
          if (bus.enable && (first_conv || timer >= TMR_LAST)) begin
            state      <= SETUP;
            timer      <= '0;
            first_conv <= 1'b0;
            cs_n_q     <= 1'b0;
            div_cnt    <= '0;
            shift_reg  <= '0;
          end
        end
        SETUP: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            state   <= SHIFT;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            sclk_q  <= ~sclk_q;
            if (!sclk_q) begin
              shift_reg <= {shift_reg[DATA_BITS-2:0], bus.miso};
              bit_cnt   <= bit_cnt + 1'b1;
            end else if (bit_cnt == BITS_ALL) begin
              // Final falling edge: release the sensor and publish in the same cycle
              state        <= DONE;
              cs_n_q       <= 1'b1;
              temp_valid_q <= 1'b1;
              temp_q       <= (shift_reg > SAT_MAX) ? 6'd63 : shift_reg[5:0];
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sclk       = sclk_q;
  assign bus.cs_n       = cs_n_q;
  assign bus.temp       = temp_q;
  assign bus.temp_valid = temp_valid_q;
  assign bus.busy       = ~cs_n_q;

endmodule

// File: doc/temp_spi_reader.md
Name: temp_spi_reader

Overview:
- Producer side of the 6-bit `temp` bus consumed by the over-temperature decoder.
- Periodically reads an unsigned 8-bit Celsius value from a serial (SPI-mode-0, read-only) temperature sensor.
- Saturates the value to 6 bits and holds it in a register.
- Pulses `temp_valid` each time a new value is latched.

Parameters:
- CLK_DIV, 25: system clock cycles per SCLK half-period; must be ≥1.
- DATA_BITS, 8: bits shifted in per conversion, MSB first; must be ≥6.
- SAMPLE_PERIOD, 100000: clk cycles from one conversion start to the next.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  periodic conversions run while high.
- miso  input  1  serial data from sensor.
- sclk  output  1  serial clock to sensor, idle low.
- cs_n  output  1  sensor chip select, active low.
- temp  output  6  last converted temperature, saturated to 0..63.
- temp_valid  output  1  one-cycle strobe when `temp` updates.
- busy  output  1  high while `cs_n` is low.

Behaviour:
- Reset (synchronous, active-high): sclk=0, cs_n=1, temp=0, temp_valid=0, busy=0, FSM=IDLE, all counters=0, shift register=0.
  - Reset asserted mid-conversion aborts it: the next cycle shows cs_n=1 and sclk=0, and no temp_valid is issued.
- FSM states: IDLE, SETUP, SHIFT, DONE.
- IDLE:
  - Period timer counts each cycle.
  - Go to SETUP when enable=1 and either (timer ≥ SAMPLE_PERIOD−1) or this is the first conversion after reset or after enable rises.
  - Timer clears on entering SETUP.
  - cs_n=1, sclk=0.
- SETUP:
  - cs_n=0, sclk=0 for CLK_DIV cycles (sensor setup time), then go to SHIFT.
- SHIFT:
  - div counter runs 0..CLK_DIV−1; on wrap, sclk toggles.
  - On each 0→1 toggle, `miso` (value present in that cycle) is shifted into the LSB of the shift register, and the bit counter increments.
  - After the DATA_BITS-th falling edge (sclk back to 0), go to DONE.
  - SHIFT lasts exactly 2·DATA_BITS·CLK_DIV cycles.
- DONE (one cycle):
  - cs_n=1.
  - temp ← (shift value > 63) ? 63 : shift value[5:0].
  - temp_valid=1 for this cycle only.
  - Go to IDLE.
- Totals:
  - cs_n low for CLK_DIV·(1+2·DATA_BITS) cycles.
  - busy = ~cs_n.
  - Period timer keeps counting through SETUP/SHIFT/DONE, so start-to-start spacing is SAMPLE_PERIOD.
  - If SAMPLE_PERIOD ≤ conversion length, the next conversion starts the cycle after DONE returns to IDLE.
- enable deasserted mid-conversion: the current conversion completes normally (temp_valid issued); the FSM then stays in IDLE until enable=1.
- temp holds its value between conversions; it changes only in DONE or on reset.
- Width rule: saturation is computed on the full DATA_BITS value; no sign handling, since the sensor value is unsigned.

Test Plan:
All scenarios use CLK_DIV=2, DATA_BITS=8, SAMPLE_PERIOD=100.
- Reset: hold reset 3 cycles with miso=1, enable=1 → sclk=0, cs_n=1, temp=0, temp_valid=0, busy=0 throughout.
- Single read: enable=1, sensor model drives 0x1B (27) MSB-first, changing on sclk falling edge →
  - cs_n low for exactly 34 cycles; 8 sclk pulses, each high 2 cycles;
  - temp=27 with a single-cycle temp_valid;
  - downstream decoder sees temp_alta=0.
- Threshold and period: next conversion with 0x1C →
  - cs_n falls exactly 100 cycles after the previous fall;
  - temp=28, one temp_valid; decoder temp_alta=1.
- Saturation: sensor returns 0xC8 (200) → temp=63; sensor returns 0x3F → temp=63; sensor returns 0x00 → temp=0.
- Enable drop: deassert enable during the 3rd sclk high → conversion completes, temp_valid pulses once, and no further cs_n falls for 300 cycles. Re-assert enable → cs_n falls within 2 cycles.
- Reset mid-SHIFT: assert reset at the 5th sclk rising edge →
  - next cycle: cs_n=1, sclk=0, temp=0, no temp_valid;
  - after release with enable=1, a fresh full 34-cycle conversion occurs.
